// File: rtl/scan_motion_pkg.sv
// rtl/scan_motion_pkg.sv - States, direction encodings and default timing for the scan motion sequencer
package scan_motion_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HOME      = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_FIRST_ROW = 3'd3;
  localparam logic [2:0] ST_SCAN      = 3'd4;
  localparam logic [2:0] ST_TRAVERSE  = 3'd5;
  localparam logic [2:0] ST_FINISHED  = 3'd6;
  localparam logic [2:0] ST_FAULT     = 3'd7;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_STEP_DIV        = 1024;
  localparam int DEF_PULSE_WIDTH     = 64;
  localparam int DEF_DIR_SETUP       = 32;
  localparam int DEF_FIRST_ROW_STEPS = 550;
  localparam int DEF_ROW_STEPS       = 300;
  localparam int DEF_NUM_ROWS        = 16;
  localparam int DEF_HOME_MAX_STEPS  = 65535;

endpackage

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - Step period divider and fixed-width step pulse generator
module step_pulse_gen
  import scan_motion_pkg::*;
#(
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step,
  output logic stepTick
);

  localparam int DW = $clog2(STEP_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(PULSE_WIDTH - 1);

  logic [DW-1:0] divCount;
  logic [DW-1:0] holdCount;

  assign stepTick = enable && !clear && (divCount == DIV_LAST);

  // A pulse outlives its enable so the driver always sees full width; only clear truncates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCount  <= '0;
      holdCount <= '0;
      step      <= 1'b0;
    end else begin
      if (!enable || clear || stepTick) divCount <= '0;
      else divCount <= divCount + 1'b1;

      if (clear) begin
        step      <= 1'b0;
        holdCount <= '0;
      end else if (stepTick) begin
        step      <= 1'b1;
        holdCount <= HOLD_LAST;
      end else if (step) begin
        if (holdCount == '0) step <= 1'b0;
        else holdCount <= holdCount - 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_motion_sequencer.sv
// rtl/scan_motion_sequencer.sv - Homes the scan head, then steps row by row handing each row to the selector
module scan_motion_sequencer
  import scan_motion_pkg::*;
#(
  parameter int STEP_DIV        = DEF_STEP_DIV,
  parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH,
  parameter int DIR_SETUP       = DEF_DIR_SETUP,
  parameter int FIRST_ROW_STEPS = DEF_FIRST_ROW_STEPS,
  parameter int ROW_STEPS       = DEF_ROW_STEPS,
  parameter int NUM_ROWS        = DEF_NUM_ROWS,
  parameter int HOME_MAX_STEPS  = DEF_HOME_MAX_STEPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       limitSwitch,
  input  logic       selectorComplete,
  output logic       startSelector,
  output logic       direction,
  output logic       step,
  output logic [7:0] rowIndex,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam logic [15:0] HOME_TGT    = 16'(HOME_MAX_STEPS);
  localparam logic [15:0] FIRST_TGT   = 16'(FIRST_ROW_STEPS);
  localparam logic [15:0] ROW_TGT     = 16'(ROW_STEPS);
  localparam logic [15:0] SETTLE_LAST = 16'(DIR_SETUP - 1);
  localparam logic [7:0]  LAST_ROW    = 8'(NUM_ROWS - 1);

  logic [2:0]  state;
  logic [15:0] stepCount;
  logic [15:0] settleCnt;
  logic        limitMeta;
  logic        limitSync;
  logic        motionOn;
  logic        stepTick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      limitMeta <= 1'b0;
      limitSync <= 1'b0;
    end else begin
      limitMeta <= limitSwitch;
      limitSync <= limitMeta;
    end
  end

  // Motion drops in the same cycle a target or the home switch is seen, so no extra step escapes.
  always_comb begin
    motionOn = 1'b0;
    if (!abort) begin
      case (state)
        ST_HOME:      motionOn = !limitSync && (stepCount != HOME_TGT);
        ST_FIRST_ROW: motionOn = (stepCount != FIRST_TGT);
        ST_TRAVERSE:  motionOn = (stepCount != ROW_TGT);
        default:      motionOn = 1'b0;
      endcase
    end
  end

  step_pulse_gen #(
    .STEP_DIV    (STEP_DIV),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_pulse (
    .clk      (clk),
    .reset    (reset),
    .enable   (motionOn),
    .clear    (abort),
    .step     (step),
    .stepTick (stepTick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      stepCount     <= '0;
      settleCnt     <= '0;
      rowIndex      <= '0;
      direction     <= DIR_UP;
      startSelector <= 1'b0;
    end else begin
      startSelector <= 1'b0;
      settleCnt     <= (state == ST_SETTLE && !abort) ? settleCnt + 16'd1 : '0;

      if (!motionOn) stepCount <= '0;
      else if (stepTick) stepCount <= stepCount + 16'd1;

      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_FINISHED, ST_FAULT: begin
            if (start) begin
              state     <= ST_HOME;
              rowIndex  <= '0;
              direction <= DIR_UP;
            end
          end
          ST_HOME: begin
            if (limitSync) begin
              direction <= DIR_DOWN;
              state     <= ST_SETTLE;
            end else if (stepCount == HOME_TGT) begin
              state <= ST_FAULT;
            end
          end
          ST_SETTLE: if (settleCnt == SETTLE_LAST) state <= ST_FIRST_ROW;
          ST_FIRST_ROW: begin
            if (stepCount == FIRST_TGT) begin
              state         <= ST_SCAN;
              startSelector <= 1'b1;
            end
          end
          ST_TRAVERSE: begin
            if (stepCount == ROW_TGT) begin
              state         <= ST_SCAN;
              startSelector <= 1'b1;
            end
          end
          ST_SCAN: begin
            if (selectorComplete) begin
              if (rowIndex == LAST_ROW) begin
                state <= ST_FINISHED;
              end else begin
                rowIndex <= rowIndex + 8'd1;
                state    <= ST_TRAVERSE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != ST_IDLE) && (state != ST_FINISHED) && (state != ST_FAULT);
  assign done  = (state == ST_FINISHED);
  assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_scan_motion_sequencer.sv
// tb/tb_scan_motion_sequencer.sv - Self-checking bench for scan_motion_sequencer
module tb_scan_motion_sequencer;

  localparam int SD  = 8;
  localparam int PW  = 3;
  localparam int DS  = 4;
  localparam int FRS = 5;
  localparam int RS  = 3;
  localparam int NR  = 2;
  localparam int HMS = 20;

  localparam int EV_U = 1;
  localparam int EV_D = 2;
  localparam int EV_S = 3;

  logic clk = 1'b0;
  logic reset, start, abort, limitSwitch, selectorComplete;
  logic startSelector, direction, step, busy, done, fault;
  logic [7:0] rowIndex;

  int nAssert = 0;
  int nFail = 0;
  bit allowTrunc = 0;
  int evQ[$];
  int expQ[$];

  always #5 clk = ~clk;

  scan_motion_sequencer #(
    .STEP_DIV(SD), .PULSE_WIDTH(PW), .DIR_SETUP(DS), .FIRST_ROW_STEPS(FRS),
    .ROW_STEPS(RS), .NUM_ROWS(NR), .HOME_MAX_STEPS(HMS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .limitSwitch(limitSwitch), .selectorComplete(selectorComplete),
    .startSelector(startSelector), .direction(direction), .step(step),
    .rowIndex(rowIndex), .busy(busy), .done(done), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected event order: U per homing step, D per descent step, S per row handed to the selector.
  task automatic buildExp(input int ups);
    expQ.delete();
    repeat (ups) expQ.push_back(EV_U);
    repeat (FRS) expQ.push_back(EV_D);
    expQ.push_back(EV_S);
    for (int r = 1; r < NR; r++) begin
      repeat (RS) expQ.push_back(EV_D);
      expQ.push_back(EV_S);
    end
  endtask

  int cyc = 0, lastRise = 0, riseCyc = 0, lastDirChg = 0;
  bit havePrev = 0, mPrevStep = 0, mPrevSel = 0, mPrevDir = 1;

  always @(negedge clk) begin
    cyc++;
    if (startSelector) begin
      chk("sel_single_cycle", mPrevSel, 0);
      evQ.push_back(EV_S);
      havePrev = 0;
    end
    if (direction !== mPrevDir) begin
      lastDirChg = cyc;
      havePrev = 0;
    end
    if (!busy || !reset) havePrev = 0;
    if (step && !mPrevStep) begin
      evQ.push_back(direction ? EV_U : EV_D);
      if (havePrev) chk("step_spacing", cyc - lastRise, SD);
      if (!direction) chk("dir_setup_ok", (cyc - lastDirChg) >= DS, 1);
      lastRise = cyc;
      riseCyc = cyc;
      havePrev = 1;
    end
    if (!step && mPrevStep && !allowTrunc) chk("pulse_width", cyc - riseCyc, PW);
    mPrevStep = step;
    mPrevSel = startSelector;
    mPrevDir = direction;
  end

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runScan(input int upN, input bit preHigh, input int selDelay, input bit stray);
    int ups, selCd, strayCd, dirFall, firstDown, nEv;
    bit pStep, pDir, strayUsed;
    limitSwitch = preHigh;
    repeat (4) @(negedge clk);
    evQ.delete();
    pulseStart();
    ups = 0; selCd = 0; strayCd = 0; dirFall = -1; firstDown = -1;
    pStep = step; pDir = direction; strayUsed = 0;
    for (int n = 0; n < 3000 && !done && !fault; n++) begin
      @(negedge clk);
      selectorComplete = 1'b0;
      if (step && !pStep) begin
        if (direction) begin
          ups++;
          if (ups == upN) limitSwitch = 1'b1;
        end else if (firstDown < 0) firstDown = n;
      end
      if (pDir && !direction) dirFall = n;
      pStep = step;
      pDir = direction;
      if (selCd > 0) begin
        selCd--;
        if (selCd == 0) begin
          selectorComplete = 1'b1;
          if (stray && !strayUsed) begin
            strayCd = 3;
            strayUsed = 1;
          end
        end
      end else if (strayCd > 0) begin
        strayCd--;
        if (strayCd == 0) selectorComplete = 1'b1;
      end
      if (startSelector) selCd = selDelay;
    end
    selectorComplete = 1'b0;
    repeat (4) @(negedge clk);
    chk("first_down_latency", firstDown - dirFall, DS + SD);
    chk("scan_done", done, 1);
    chk("scan_row_index", rowIndex, NR - 1);
    chk("scan_busy", busy, 0);
    chk("scan_fault", fault, 0);
    chk("scan_step_idle", step, 0);
    buildExp(preHigh ? 0 : upN);
    chk("event_count", evQ.size(), expQ.size());
    nEv = (evQ.size() < expQ.size()) ? evQ.size() : expQ.size();
    for (int i = 0; i < nEv; i++) chk("event_seq", evQ[i], expQ[i]);
  endtask

  initial begin
    int rises, ups;
    bit pStep, ok;
    reset = 1'b0; start = 1'b0; abort = 1'b0; limitSwitch = 1'b0; selectorComplete = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_selector", startSelector, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_direction", direction, 1);
    chk("rst_row_index", rowIndex, 0);
    reset = 1'b1;
    @(negedge clk);

    runScan(2, 1'b0, 10, 1'b1);
    runScan(0, 1'b1, 10, 1'b0);
    for (int k = 0; k < 3; k++)
      runScan($urandom_range(1, 4), 1'b0, $urandom_range(1, 12), 1'($urandom_range(0, 1)));

    // Homing with the switch never seen
    limitSwitch = 1'b0;
    repeat (4) @(negedge clk);
    evQ.delete();
    pulseStart();
    for (int n = 0; n < 1000 && !fault; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("timeout_fault", fault, 1);
    chk("timeout_step", step, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_done", done, 0);
    chk("timeout_step_count", evQ.size(), HMS);
    ups = 0;
    foreach (evQ[i]) if (evQ[i] == EV_U) ups++;
    chk("timeout_up_steps", ups, HMS);
    repeat (20) @(negedge clk);
    chk("fault_hold", fault, 1);

    // Abort on the second high cycle of a homing step
    pulseStart();
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (step) begin
        ok = 1;
        break;
      end
    end
    chk("abort_step_seen", ok, 1);
    allowTrunc = 1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_step_cut", step, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fault", fault, 0);
    chk("abort_done", done, 0);
    abort = 1'b0;
    rises = 0; pStep = 0;
    repeat (40) begin
      @(negedge clk);
      if (step && !pStep) rises++;
      pStep = step;
    end
    chk("abort_no_steps", rises, 0);
    chk("abort_idle", busy, 0);
    allowTrunc = 0;

    // Reset during a traverse step pulse
    limitSwitch = 1'b1;
    repeat (4) @(negedge clk);
    pulseStart();
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (startSelector) begin
        ok = 1;
        break;
      end
    end
    chk("rst_mid_sel_seen", ok, 1);
    repeat (5) @(negedge clk);
    selectorComplete = 1'b1;
    @(negedge clk);
    selectorComplete = 1'b0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (step) begin
        ok = 1;
        break;
      end
    end
    chk("rst_mid_step_seen", ok, 1);
    chk("rst_mid_row_before", rowIndex, 1);
    allowTrunc = 1;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_start_selector", startSelector, 0);
    chk("rst_mid_step", step, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_fault", fault, 0);
    chk("rst_mid_direction", direction, 1);
    chk("rst_mid_row_index", rowIndex, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rises = 0; pStep = 0;
    repeat (40) begin
      @(negedge clk);
      if (step && !pStep) rises++;
      pStep = step;
    end
    chk("rst_release_no_steps", rises, 0);
    chk("rst_release_busy", busy, 0);
    allowTrunc = 0;

    runScan($urandom_range(1, 4), 1'b0, $urandom_range(1, 12), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/scan_motion_sequencer.md
SCAN_MOTION_SEQUENCER -- requirements
Module: scan_motion_sequencer

Interface
REQ-001 Parameter STEP_DIV, default 1024: clock cycles per step period, minimum 4.
REQ-002 Parameter PULSE_WIDTH, default 64: step high time in clocks, 1 to STEP_DIV-2.
REQ-003 Parameter DIR_SETUP, default 32: clocks from a direction change to the first step, minimum 1.
REQ-004 Parameter FIRST_ROW_STEPS, default 550: steps from home to row 0, minimum 1.
REQ-005 Parameter ROW_STEPS, default 300: steps between rows, minimum 1.
REQ-006 Parameter NUM_ROWS, default 16: rows per scan, 1 to 255.
REQ-007 Parameter HOME_MAX_STEPS, default 65535: homing step limit before fault.
REQ-008 clk  in  1  system clock; all logic on the rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  one-cycle request to begin a scan.
REQ-011 abort  in  1  level; stops motion and returns to IDLE.
REQ-012 limitSwitch  in  1  home switch, asynchronous to clk; 1 means at home.
REQ-013 selectorComplete  in  1  pulse from the row selector meaning the row read is done.
REQ-014 startSelector  out  1  one-cycle pulse that starts a row read.
REQ-015 direction  out  1  1 = UP (toward home), 0 = DOWN.
REQ-016 step  out  1  step pulse to the driver.
REQ-017 rowIndex  out  8  index of the current row.
REQ-018 busy  out  1  high in any state except IDLE, FINISHED and FAULT.
REQ-019 done  out  1  high in FINISHED.
REQ-020 fault  out  1  high in FAULT.

Function
REQ-021 States SHALL be: IDLE, HOME, SETTLE, FIRST_ROW, SCAN, TRAVERSE, FINISHED, FAULT.
REQ-022 limitSwitch SHALL pass through a two-flop synchroniser; limitSync is the synchronised value and adds 2 cycles of latency.
REQ-023 start SHALL act only in IDLE, FINISHED or FAULT: it clears rowIndex and the step counter, then enters HOME.
REQ-024 In HOME: direction is UP and motion is on.
- When limitSync is 1 (including at entry), motion stops, direction goes DOWN, and the next state is SETTLE.
- When the step count reaches HOME_MAX_STEPS with limitSync still 0, the next state is FAULT.
REQ-025 SETTLE SHALL wait DIR_SETUP cycles with no steps, then enter FIRST_ROW.
REQ-026 FIRST_ROW and TRAVERSE SHALL move DOWN until the step count equals the target (FIRST_ROW_STEPS or ROW_STEPS).
- On that cycle, motion stops, startSelector pulses for one cycle, and the next state is SCAN.
- No step beyond the target is issued.
REQ-027 In SCAN, selectorComplete SHALL act as follows:
- rowIndex equal to NUM_ROWS-1: next state is FINISHED.
- Otherwise: rowIndex increments and the next state is TRAVERSE.
- selectorComplete in any other state is ignored.
REQ-028 Step generation while motion is on:
- A divider counts 0 to STEP_DIV-1 and wraps.
- At wrap, step rises and the step count increments in the same cycle.
- step stays high for exactly PULSE_WIDTH cycles.
- The first step comes STEP_DIV cycles after motion turns on.
REQ-029 When motion turns off, the divider and step count SHALL clear on the next cycle, and a step pulse already in progress completes its full width.
REQ-030 When abort is high in any state, the next state SHALL be IDLE and step SHALL go to 0 immediately (the pulse is truncated); abort takes priority over start and selectorComplete.
REQ-031 While motion is on, direction SHALL NOT change.
REQ-032 startSelector SHALL never be high for two consecutive cycles.
REQ-033 In FINISHED and FAULT, outputs SHALL hold until start or abort.

Reset
REQ-034 When reset is low, the following SHALL be forced asynchronously:
- state to IDLE;
- startSelector, step, busy, done and fault to 0;
- direction to UP (1);
- rowIndex, the divider, the step count, the settle counter and the synchroniser to 0.
REQ-035 Reset released in the middle of a pulse SHALL leave no partial pulse; the first step needs a new start.

Structure
REQ-036 Package scan_motion_pkg SHALL hold the state enumeration, the UP/DOWN constants and the default parameter values.
REQ-037 Step timing SHALL sit in sub-module step_pulse_gen, which takes the enable, STEP_DIV and PULSE_WIDTH and outputs step and a one-cycle stepTick.

Verification
All scenarios use STEP_DIV=8, PULSE_WIDTH=3, DIR_SETUP=4, FIRST_ROW_STEPS=5, ROW_STEPS=3, NUM_ROWS=2, HOME_MAX_STEPS=20 unless stated.
REQ-038 Full scan:
- Stimulus: limitSwitch rises after 2 UP steps; selectorComplete is returned 10 cycles after each startSelector.
- Response: 2 UP steps, 5 DOWN steps, startSelector, 3 DOWN steps, startSelector, then done=1 with rowIndex=1.
REQ-039 Limit already high at start:
- Stimulus: limitSwitch=1 when start is applied.
- Response: no UP step; first DOWN step comes DIR_SETUP+STEP_DIV cycles after SETTLE is entered.
REQ-040 Homing timeout:
- Stimulus: limitSwitch stays 0.
- Response: exactly 20 UP steps, then fault=1, step=0 and busy=0.
REQ-041 Abort mid-pulse:
- Stimulus: abort asserted on the second high cycle of a step.
- Response: step=0 on the next cycle, state IDLE, and no further steps.
REQ-042 Pulse timing:
- Check: every step high time is exactly 3 cycles and the rising-edge spacing is 8 cycles.
- Check: direction is stable for at least 4 cycles before every DOWN step.
REQ-043 Mid-scan reset and stray selectorComplete:
- Stimulus: reset pulsed during TRAVERSE.
- Response: outputs take their REQ-034 values; after release, step stays 0 until start.
- Stimulus: selectorComplete in TRAVERSE.
- Response: ignored.
